// File: rtl/dq_regfile.sv
// Clocked DQ register bank: DEPTH x WIDTH storage with per-bit write mask,
// per-entry valid flags, two combinational read ports and optional write bypass.
module dq_regfile #(
  parameter  int WIDTH  = 4,
  parameter  int DEPTH  = 4,
  parameter  bit BYPASS = 1'b0,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] wmask,
  input  logic [AW-1:0]    raddr0,
  output logic [WIDTH-1:0] rdata0,
  output logic             rvld0,
  input  logic [AW-1:0]    raddr1,
  output logic [WIDTH-1:0] rdata1,
  output logic             rvld1
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] vld;

  logic             wr_in_range;
  logic             rd0_in_range;
  logic             rd1_in_range;
  logic             wr_fire;
  logic             fwd_ok;
  logic             fwd0;
  logic             fwd1;
  logic [WIDTH-1:0] wr_merged;

  // A power-of-two depth cannot be addressed out of range, so skip the compare.
  generate
    if (DEPTH == (1 << AW)) begin : g_pow2
      assign wr_in_range  = 1'b1;
      assign rd0_in_range = 1'b1;
      assign rd1_in_range = 1'b1;
    end else begin : g_npow2
      localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
      assign wr_in_range  = (waddr  < DEPTH_A);
      assign rd0_in_range = (raddr0 < DEPTH_A);
      assign rd1_in_range = (raddr1 < DEPTH_A);
    end
  endgenerate

  assign wr_fire   = we & wr_in_range;
  assign wr_merged = (mem[waddr] & ~wmask) | (wdata & wmask);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      vld <= '0;
    end else if (wr_fire) begin
      mem[waddr] <= wr_merged;
      vld[waddr] <= 1'b1;
    end
  end

  // Forwarding only for a write that will actually commit at this edge.
  assign fwd_ok = BYPASS && wr_fire && !rst && !clr;
  assign fwd0   = fwd_ok && (raddr0 == waddr);
  assign fwd1   = fwd_ok && (raddr1 == waddr);

  always_comb begin
    rdata0 = '0;
    rvld0  = 1'b0;
    if (fwd0) begin
      rdata0 = wr_merged;
      rvld0  = 1'b1;
    end else if (rd0_in_range) begin
      rdata0 = mem[raddr0];
      rvld0  = vld[raddr0];
    end
  end

  always_comb begin
    rdata1 = '0;
    rvld1  = 1'b0;
    if (fwd1) begin
      rdata1 = wr_merged;
      rvld1  = 1'b1;
    end else if (rd1_in_range) begin
      rdata1 = mem[raddr1];
      rvld1  = vld[raddr1];
    end
  end

endmodule

// File: tb/tb_dq_regfile.sv
// Directed scoreboard bench for dq_regfile: three instances (no bypass, bypass,
// depth 3) share stimulus; expectations are queued and checked at the falling edge.
module tb_dq_regfile;

  logic       clk = 1'b0;
  logic       rst, clr, we;
  logic [1:0] waddr, raddr0, raddr1;
  logic [3:0] wdata, wmask;

  logic [3:0] rd0_a, rd1_a, rd0_b, rd1_b, rd0_c, rd1_c;
  logic       rv0_a, rv1_a, rv0_b, rv1_b, rv0_c, rv1_c;

  dq_regfile #(.WIDTH(4), .DEPTH(4), .BYPASS(1'b0)) u_a (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .raddr0(raddr0), .rdata0(rd0_a), .rvld0(rv0_a),
    .raddr1(raddr1), .rdata1(rd1_a), .rvld1(rv1_a));

  dq_regfile #(.WIDTH(4), .DEPTH(4), .BYPASS(1'b1)) u_b (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .raddr0(raddr0), .rdata0(rd0_b), .rvld0(rv0_b),
    .raddr1(raddr1), .rdata1(rd1_b), .rvld1(rv1_b));

  dq_regfile #(.WIDTH(4), .DEPTH(3), .BYPASS(1'b0)) u_c (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .raddr0(raddr0), .rdata0(rd0_c), .rvld0(rv0_c),
    .raddr1(raddr1), .rdata1(rd1_c), .rvld1(rv1_c));

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         inst;  // 0 = u_a, 1 = u_b, 2 = u_c
    int         port;
    logic [3:0] data;
    logic       vld;
  } exp_t;

  exp_t sb[$];
  bit   sample_req = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Monitor: when a sample is requested, drain every queued expectation.
  always @(negedge clk) begin
    if (sample_req) begin
      while (sb.size() > 0) begin
        exp_t       e;
        logic [3:0] ad;
        logic       av;
        e = sb.pop_front();
        case (e.inst * 2 + e.port)
          0:       begin ad = rd0_a; av = rv0_a; end
          1:       begin ad = rd1_a; av = rv1_a; end
          2:       begin ad = rd0_b; av = rv0_b; end
          3:       begin ad = rd1_b; av = rv1_b; end
          4:       begin ad = rd0_c; av = rv0_c; end
          default: begin ad = rd1_c; av = rv1_c; end
        endcase
        checks++;
        if (ad !== e.data || av !== e.vld) begin
          errors++;
          $display("FAIL %s inst%0d port%0d: got data=%b vld=%b, expected data=%b vld=%b",
                   e.name, e.inst, e.port, ad, av, e.data, e.vld);
        end
      end
      sample_req = 1'b0;
    end
  end

  task automatic drive(input logic r, input logic c, input logic w, input logic [1:0] wa,
                       input logic [3:0] wd, input logic [3:0] wm,
                       input logic [1:0] ra0, input logic [1:0] ra1);
    rst = r; clr = c; we = w; waddr = wa; wdata = wd; wmask = wm;
    raddr0 = ra0; raddr1 = ra1;
  endtask

  task automatic expect1(input string n, input int inst, input int port,
                         input logic [3:0] d, input logic v);
    exp_t e;
    e.name = n; e.inst = inst; e.port = port; e.data = d; e.vld = v;
    sb.push_back(e);
  endtask

  // Expectations for one port on all three instances.
  task automatic expect3(input string n, input int port,
                         input logic [3:0] da, input logic va,
                         input logic [3:0] db, input logic vb,
                         input logic [3:0] dc, input logic vc);
    expect1(n, 0, port, da, va);
    expect1(n, 1, port, db, vb);
    expect1(n, 2, port, dc, vc);
  endtask

  task automatic tick();
    if (sb.size() > 0) sample_req = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 2'd0, 4'h0, 4'h0, 2'd0, 2'd0);
    tick();

    // Reset sweep
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 2'd0, 4'h0, 4'h0, 2'(i), 2'(3 - i));
      expect3("reset_p0", 0, 4'h0, 0, 4'h0, 0, 4'h0, 0);
      expect3("reset_p1", 1, 4'h0, 0, 4'h0, 0, 4'h0, 0);
      tick();
    end

    // Full write to addr 2; bypass instance forwards in the same cycle
    drive(0, 0, 1, 2'd2, 4'b1010, 4'b1111, 2'd2, 2'd1);
    expect3("wr_same_cycle", 0, 4'b0000, 0, 4'b1010, 1, 4'b0000, 0);
    expect3("wr_other_port", 1, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0);
    tick();
    drive(0, 0, 0, 2'd0, 4'h0, 4'h0, 2'd2, 2'd1);
    expect3("wr_read_back", 0, 4'b1010, 1, 4'b1010, 1, 4'b1010, 1);
    expect3("wr_unwritten", 1, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0);
    tick();

    // Masked write merges with stored bits
    drive(0, 0, 1, 2'd2, 4'b0101, 4'b0011, 2'd0, 2'd0);
    tick();
    drive(0, 0, 0, 2'd0, 4'h0, 4'h0, 2'd2, 2'd2);
    expect3("masked_p0", 0, 4'b1001, 1, 4'b1001, 1, 4'b1001, 1);
    expect3("masked_p1", 1, 4'b1001, 1, 4'b1001, 1, 4'b1001, 1);
    tick();

    // Zero-mask write to addr 3 only sets valid; out of range on depth 3
    drive(0, 0, 1, 2'd3, 4'b1111, 4'b0000, 2'd3, 2'd0);
    expect3("zmask_fwd", 0, 4'b0000, 0, 4'b0000, 1, 4'b0000, 0);
    tick();
    drive(0, 0, 0, 2'd0, 4'h0, 4'h0, 2'd3, 2'd0);
    expect3("zmask_after", 0, 4'b0000, 1, 4'b0000, 1, 4'b0000, 0);
    tick();

    // Bypass: entry 1 = 0011, then masked write 1100/1100 with read in same cycle
    drive(0, 0, 1, 2'd1, 4'b0011, 4'b1111, 2'd0, 2'd0);
    tick();
    drive(0, 0, 1, 2'd1, 4'b1100, 4'b1100, 2'd1, 2'd1);
    expect3("bypass_p0", 0, 4'b0011, 1, 4'b1111, 1, 4'b0011, 1);
    expect3("bypass_p1", 1, 4'b0011, 1, 4'b1111, 1, 4'b0011, 1);
    tick();
    drive(0, 0, 0, 2'd0, 4'h0, 4'h0, 2'd1, 2'd0);
    expect3("bypass_after", 0, 4'b1111, 1, 4'b1111, 1, 4'b1111, 1);
    tick();

    // Write to addr 3: real entry on depth 4, ignored on depth 3
    drive(0, 0, 1, 2'd3, 4'b0110, 4'b1111, 2'd0, 2'd0);
    tick();
    drive(0, 0, 0, 2'd0, 4'h0, 4'h0, 2'd3, 2'd2);
    expect3("oor_read", 0, 4'b0110, 1, 4'b0110, 1, 4'b0000, 0);
    expect3("oor_untouched", 1, 4'b1001, 1, 4'b1001, 1, 4'b1001, 1);
    tick();

    // Clear beats a same-cycle write; no forwarding during clear
    drive(0, 1, 1, 2'd0, 4'b1111, 4'b1111, 2'd0, 2'd2);
    expect3("clr_pre_p0", 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0);
    expect3("clr_pre_p1", 1, 4'b1001, 1, 4'b1001, 1, 4'b1001, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 2'd0, 4'h0, 4'h0, 2'(i), 2'(3 - i));
      expect3("clr_sweep_p0", 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0);
      expect3("clr_sweep_p1", 1, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0);
      tick();
    end

    // Reset during a write: entry ends up zero and invalid
    drive(0, 0, 1, 2'd1, 4'b0111, 4'b1111, 2'd0, 2'd0);
    tick();
    drive(1, 0, 1, 2'd1, 4'b1010, 4'b1111, 2'd0, 2'd0);
    tick();
    drive(0, 0, 0, 2'd0, 4'h0, 4'h0, 2'd1, 2'd1);
    expect3("rst_midwr_p0", 0, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0);
    expect3("rst_midwr_p1", 1, 4'b0000, 0, 4'b0000, 0, 4'b0000, 0);
    tick();

    // Back-to-back masked writes accumulate
    drive(0, 0, 1, 2'd0, 4'b1100, 4'b1100, 2'd1, 2'd1);
    tick();
    drive(0, 0, 1, 2'd0, 4'b0011, 4'b0010, 2'd0, 2'd1);
    expect3("b2b_mid", 0, 4'b1100, 1, 4'b1110, 1, 4'b1100, 1);
    tick();
    drive(0, 0, 0, 2'd0, 4'h0, 4'h0, 2'd0, 2'd0);
    expect3("b2b_final_p0", 0, 4'b1110, 1, 4'b1110, 1, 4'b1110, 1);
    expect3("b2b_final_p1", 1, 4'b1110, 1, 4'b1110, 1, 4'b1110, 1);
    tick();

    @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1, "watchdog");
  end

endmodule
